// File: rtl/ccff_loader.sv
// Configuration-chain head loader: serializes bitstream words MSB-first onto
// ccff_head while capturing ccff_tail into left-justified readback words.
module ccff_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              ccff_head,
  output logic              ccff_shift,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
);

  localparam int BLW = $clog2(CHAIN_LEN + 1);
  localparam int NBW = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_STALL,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [BLW-1:0]    bits_left_q, bits_left_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [NBW-1:0]    cnt_q, cnt_d;
  logic [NBW-1:0]    nb_q, nb_d;
  logic [WORD_W-1:0] cap_q, cap_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;
  logic              head_q, head_d;
  logic              shift_q, shift_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              rb_free;
  logic [NBW-1:0]    nb_calc;
  logic [WORD_W-1:0] cap_shifted;
  logic [WORD_W-1:0] cap_just;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; without this the tool infers a latch.
    state_d     = state_q;
    bits_left_d = bits_left_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    nb_d        = nb_q;
    cap_d       = cap_q;
    rb_data_d   = rb_data_q;
    rb_valid_d  = rb_valid_q & ~rb_ready;
    done_d      = 1'b0;

    // The holding register is usable if empty or being emptied on this edge.
    rb_free     = ~rb_valid_q | rb_ready;
    nb_calc     = (int'(bits_left_q) >= WORD_W) ? NBW'(WORD_W) : NBW'(bits_left_q);
    cap_shifted = (cap_q << 1) | WORD_W'(ccff_tail);
    cap_just    = cap_shifted << (WORD_W - int'(nb_q));

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FETCH;
          bits_left_d = BLW'(CHAIN_LEN);
        end
      end
      S_FETCH: begin
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          nb_d    = nb_calc;
          cnt_d   = nb_calc;
          cap_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d      = data_q << 1;
        cap_d       = cap_shifted;
        bits_left_d = bits_left_q - 1'b1;
        cnt_d       = cnt_q - 1'b1;
        if (cnt_q == NBW'(1)) begin
          cap_d = cap_just;
          if (rb_free) begin
            rb_data_d  = cap_just;
            rb_valid_d = 1'b1;
            state_d    = (bits_left_q == BLW'(1)) ? S_DRAIN : S_FETCH;
          end else begin
            state_d = S_STALL;
          end
        end
      end
      S_STALL: begin
        if (rb_free) begin
          rb_data_d  = cap_q;
          rb_valid_d = 1'b1;
          state_d    = (bits_left_q == '0) ? S_DRAIN : S_FETCH;
        end
      end
      S_DRAIN: begin
        if (rb_free) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up with it.
    shift_d    = (state_d == S_SHIFT);
    head_d     = shift_d & data_d[WORD_W-1];
    in_ready_d = (state_d == S_FETCH);
    busy_d     = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q     <= S_IDLE;
      bits_left_q <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      nb_q        <= '0;
      cap_q       <= '0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
      head_q      <= 1'b0;
      shift_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      nb_q        <= nb_d;
      cap_q       <= cap_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
      head_q      <= head_d;
      shift_q     <= shift_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign rb_data    = rb_data_q;
  assign rb_valid   = rb_valid_q;
  assign ccff_head  = head_q;
  assign ccff_shift = shift_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: a 20-flop chain model on the serial pins, a directed
// load sequence, and a scoreboard of expected readback words.
module tb_ccff_loader;

  logic       prog_clk = 1'b0;
  logic       pReset;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] rb_data;
  logic       rb_valid;
  logic       rb_ready;
  logic       ccff_head;
  logic       ccff_shift;
  logic       ccff_tail;
  logic       busy;
  logic       done;

  logic [19:0] chain = 20'h00000;

  int n_tests = 0;
  int n_fail  = 0;
  int shift_cnt = 0;
  int in_cnt    = 0;
  int done_cnt  = 0;
  logic [7:0] sb[$];
  int sb_rd = 0;

  ccff_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rb_data   (rb_data),
    .rb_valid  (rb_valid),
    .rb_ready  (rb_ready),
    .ccff_head (ccff_head),
    .ccff_shift(ccff_shift),
    .ccff_tail (ccff_tail),
    .busy      (busy),
    .done      (done)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: bit 0 is next to the head, bit 19 drives the tail.
  always @(posedge prog_clk) begin
    if (ccff_shift) chain <= {chain[18:0], ccff_head};
  end
  assign ccff_tail = chain[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts pin events and scores every accepted readback word.
  always @(negedge prog_clk) begin
    if (pReset) begin
      if (ccff_shift) shift_cnt++;
      if (in_valid && in_ready) in_cnt++;
      if (done) done_cnt++;
      if (rb_valid && rb_ready) begin
        if (sb_rd < sb.size()) begin
          check("rb_word", {24'h0, rb_data}, {24'h0, sb[sb_rd]});
          sb_rd++;
        end else begin
          n_tests++;
          n_fail++;
          $display("FAIL rb_unexpected: got 0x%0h, expected no word", rb_data);
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit stall);
    int s0;
    if (stall) begin
      for (int k = 0; k < 100 && !in_ready; k++) @(negedge prog_clk);
      s0 = shift_cnt;
      repeat (5) begin
        @(negedge prog_clk);
        check("stall_no_shift", {31'h0, ccff_shift}, 32'h0);
      end
      check("stall_shift_count", shift_cnt - s0, 0);
    end
    @(posedge prog_clk); #1;
    in_data  = w;
    in_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge prog_clk);
      if (in_ready) break;
    end
    check("in_ready_seen", {31'h0, in_ready}, 32'h1);
    @(posedge prog_clk); #1 in_valid = 1'b0;
  endtask

  // mode: 0 nominal, 1 readback backpressure, 2 input stall, 3 start while busy
  task automatic do_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                         input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                         input int mode, input logic [19:0] exp_chain);
    int s0, i0, d0;
    s0 = shift_cnt; i0 = in_cnt; d0 = done_cnt;
    sb.push_back(e0); sb.push_back(e1); sb.push_back(e2);
    if (mode == 1) rb_ready = 1'b0;
    pulse_start();
    send_word(w0, 1'b0);
    if (mode == 3) begin
      start = 1'b1;
      @(posedge prog_clk); #1 start = 1'b0;
      check("busy_mid_shift", {31'h0, busy}, 32'h1);
    end
    send_word(w1, mode == 2);
    if (mode == 1) begin
      for (int k = 0; k < 100 && (shift_cnt - s0) < 16; k++) @(posedge prog_clk);
      repeat (4) begin
        @(negedge prog_clk);
        check("bp_shift_low", {31'h0, ccff_shift}, 32'h0);
        check("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
      end
      check("bp_rb_held", {24'h0, rb_data}, {24'h0, e0});
      check("bp_shift_frozen", shift_cnt - s0, 16);
      @(posedge prog_clk); #1 rb_ready = 1'b1;
    end
    send_word(w2, 1'b0);
    for (int k = 0; k < 300 && (done_cnt - d0) < 1; k++) @(posedge prog_clk);
    repeat (4) @(posedge prog_clk);
    #1;
    check("shift_total", shift_cnt - s0, 20);
    check("in_handshakes", in_cnt - i0, 3);
    check("done_pulses", done_cnt - d0, 1);
    check("chain_content", {12'h0, chain}, {12'h0, exp_chain});
    check("rb_all_seen", sb_rd, sb.size());
    check("busy_after", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    pReset = 1'b0; start = 1'b0; in_data = '0; in_valid = 1'b0; rb_ready = 1'b1;
    repeat (2) @(posedge prog_clk);
    #1;
    check("reset_outputs", {19'h0, in_ready, rb_valid, rb_data, ccff_head, ccff_shift, busy, done}, 32'h0);
    pReset = 1'b1;

    do_load(8'hA5, 8'h3C, 8'hF0, 8'h00, 8'h00, 8'h00, 0, 20'hA53CF);
    do_load(8'hFF, 8'h0F, 8'h90, 8'hA5, 8'h3C, 8'hF0, 0, 20'hFF0F9);
    do_load(8'h12, 8'h34, 8'h56, 8'hFF, 8'h0F, 8'h90, 0, 20'h12345);
    do_load(8'hA5, 8'h3C, 8'hF0, 8'h12, 8'h34, 8'h50, 1, 20'hA53CF);
    do_load(8'hA5, 8'h3C, 8'hF0, 8'hA5, 8'h3C, 8'hF0, 2, 20'hA53CF);
    do_load(8'h5A, 8'hC3, 8'h0F, 8'hA5, 8'h3C, 8'hF0, 3, 20'h5AC30);

    // Abort after 10 shifts: only the first readback word may appear.
    s0 = shift_cnt;
    sb.push_back(8'h5A);
    pulse_start();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    for (int k = 0; k < 100 && (shift_cnt - s0) < 10; k++) @(posedge prog_clk);
    #1 pReset = 1'b0;
    #1;
    check("abort_outputs", {19'h0, in_ready, rb_valid, rb_data, ccff_head, ccff_shift, busy, done}, 32'h0);
    repeat (3) @(negedge prog_clk);
    check("abort_rb_valid", {31'h0, rb_valid}, 32'h0);
    check("abort_shifts", shift_cnt - s0, 10);
    check("abort_chain", {12'h0, chain}, 32'h0000C044);
    check("abort_rb_seen", sb_rd, sb.size());
    @(posedge prog_clk); #1 pReset = 1'b1;

    do_load(8'hA5, 8'h3C, 8'hF0, 8'h0C, 8'h04, 8'h40, 0, 20'hA53CF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
